// File: rtl/neuron_pkg.sv
// Shared definitions for the fixed-point neuron: controller states, activation
// modes and the leaky-ReLU slope expressed as an arithmetic right shift.
package neuron_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCUMULATE,
    ST_ACTIVATE,
    ST_DONE
  } neuron_state_e;

  typedef enum logic [1:0] {
    ACT_RELU,
    ACT_NONE,
    ACT_LEAKY
  } act_mode_e;

  localparam int LEAKY_SHIFT = 3;

endpackage

// File: rtl/product_tree.sv
// Combinational multiply stage: NUM_LANES signed products reduced by a balanced
// adder tree into one sign-extended sum of width SUM_WIDTH.
module product_tree #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_LANES  = 4,
  parameter int SUM_WIDTH  = 37
) (
  input  logic [NUM_LANES*DATA_WIDTH-1:0] a,
  input  logic [NUM_LANES*DATA_WIDTH-1:0] b,
  output logic signed [SUM_WIDTH-1:0]     sum
);

  localparam int LEVELS = $clog2(NUM_LANES);
  localparam int LEAVES = 1 << LEVELS;

  logic signed [SUM_WIDTH-1:0]    node [LEAVES];
  logic signed [2*DATA_WIDTH-1:0] prod;

  // Leaves beyond NUM_LANES are zero so non-power-of-two lane counts still reduce cleanly.
  always_comb begin
    prod = '0;
    for (int i = 0; i < LEAVES; i++) begin
      node[i] = '0;
    end
    for (int i = 0; i < NUM_LANES; i++) begin
      prod = (2*DATA_WIDTH)'($signed(a[i*DATA_WIDTH +: DATA_WIDTH]))
           * (2*DATA_WIDTH)'($signed(b[i*DATA_WIDTH +: DATA_WIDTH]));
      node[i] = SUM_WIDTH'(prod);
    end
    for (int w = LEAVES; w > 1; w = w / 2) begin
      for (int k = 0; k < w / 2; k++) begin
        node[k] = node[2*k] + node[2*k+1];
      end
    end
    sum = node[0];
  end

endmodule

// File: rtl/fixed_point_neuron.sv
// Single fixed-point neuron: weighted sum over NUM_INPUTS in NUM_LANES-wide beats,
// bias add, rescale with floor, saturation and a selectable activation.
module fixed_point_neuron
  import neuron_pkg::*;
#(
  parameter int    DATA_WIDTH = 16,
  parameter int    FRAC_BITS  = 8,
  parameter int    NUM_INPUTS = 16,
  parameter int    NUM_LANES  = 4,
  parameter string ACTIVATION = "relu",
  localparam int   ADDR_WIDTH = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             input_valid,
  output logic                             input_ready,
  input  logic [NUM_INPUTS*DATA_WIDTH-1:0] inputs,
  input  logic                             weight_write,
  input  logic [ADDR_WIDTH-1:0]            weight_address,
  input  logic [DATA_WIDTH-1:0]            weight_data,
  input  logic                             bias_write,
  input  logic [DATA_WIDTH-1:0]            bias_data,
  output logic [DATA_WIDTH-1:0]            out,
  output logic                             output_valid,
  input  logic                             output_ready
);

  localparam int BEATS      = NUM_INPUTS / NUM_LANES;
  localparam int CNT_WIDTH  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int ACC_WIDTH  = 2*DATA_WIDTH + $clog2(NUM_INPUTS) + 1;
  localparam int VEC_WIDTH  = NUM_INPUTS * DATA_WIDTH;
  localparam int LANE_WIDTH = NUM_LANES * DATA_WIDTH;

  localparam act_mode_e MODE = (ACTIVATION == "none")  ? ACT_NONE :
                               (ACTIVATION == "leaky") ? ACT_LEAKY : ACT_RELU;

  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  if (NUM_INPUTS % NUM_LANES != 0) begin : g_bad_lanes
    $error("fixed_point_neuron: NUM_INPUTS must be a multiple of NUM_LANES");
  end
  if (ACTIVATION != "relu" && ACTIVATION != "none" && ACTIVATION != "leaky") begin : g_bad_act
    $error("fixed_point_neuron: ACTIVATION must be relu, none or leaky");
  end

  neuron_state_e                state_q, state_d;
  logic [CNT_WIDTH-1:0]         beat_q, beat_d;
  logic signed [ACC_WIDTH-1:0]  acc_q, acc_d;
  logic [VEC_WIDTH-1:0]         inputs_q, inputs_d;
  logic [VEC_WIDTH-1:0]         weight_q, weight_d;
  logic [VEC_WIDTH-1:0]         weight_snap_q, weight_snap_d;
  logic [DATA_WIDTH-1:0]        bias_q, bias_d;
  logic [DATA_WIDTH-1:0]        bias_snap_q, bias_snap_d;
  logic [DATA_WIDTH-1:0]        out_q, out_d;
  logic                         output_valid_q, output_valid_d;

  logic [LANE_WIDTH-1:0]        lane_x, lane_w;
  logic signed [ACC_WIDTH-1:0]  beat_sum;
  logic signed [ACC_WIDTH-1:0]  biased, scaled;
  logic signed [DATA_WIDTH-1:0] clipped, activated;

  assign lane_x = inputs_q[int'(beat_q)*LANE_WIDTH +: LANE_WIDTH];
  assign lane_w = weight_snap_q[int'(beat_q)*LANE_WIDTH +: LANE_WIDTH];

  product_tree #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_LANES  (NUM_LANES),
    .SUM_WIDTH  (ACC_WIDTH)
  ) u_product_tree (
    .a   (lane_x),
    .b   (lane_w),
    .sum (beat_sum)
  );

  // Right shift of a signed value floors toward minus infinity, which is the rounding we want.
  always_comb begin
    biased  = acc_q + ({{(ACC_WIDTH-DATA_WIDTH){bias_snap_q[DATA_WIDTH-1]}}, bias_snap_q} <<< FRAC_BITS);
    scaled  = biased >>> FRAC_BITS;
    clipped = scaled[DATA_WIDTH-1:0];
    if (scaled > SAT_MAX) begin
      clipped = SAT_MAX[DATA_WIDTH-1:0];
    end else if (scaled < SAT_MIN) begin
      clipped = SAT_MIN[DATA_WIDTH-1:0];
    end
    activated = clipped;
    if (clipped < 0) begin
      if (MODE == ACT_RELU) begin
        activated = '0;
      end else if (MODE == ACT_LEAKY) begin
        activated = clipped >>> LEAKY_SHIFT;
      end
    end
  end

  // Weights and bias are snapshotted on acceptance so a same-cycle write only affects later vectors.
  always_comb begin
    state_d        = state_q;
    beat_d         = beat_q;
    acc_d          = acc_q;
    inputs_d       = inputs_q;
    weight_d       = weight_q;
    weight_snap_d  = weight_snap_q;
    bias_d         = bias_q;
    bias_snap_d    = bias_snap_q;
    out_d          = out_q;
    output_valid_d = output_valid_q;

    unique case (state_q)
      ST_IDLE: begin
        if (input_valid) begin
          inputs_d      = inputs;
          weight_snap_d = weight_q;
          bias_snap_d   = bias_q;
          acc_d         = '0;
          beat_d        = '0;
          state_d       = ST_ACCUMULATE;
        end
        if (weight_write && (int'(weight_address) < NUM_INPUTS)) begin
          weight_d[int'(weight_address)*DATA_WIDTH +: DATA_WIDTH] = weight_data;
        end
        if (bias_write) begin
          bias_d = bias_data;
        end
      end
      ST_ACCUMULATE: begin
        acc_d  = acc_q + beat_sum;
        beat_d = beat_q + 1'b1;
        if (beat_q == CNT_WIDTH'(BEATS-1)) begin
          beat_d  = '0;
          state_d = ST_ACTIVATE;
        end
      end
      ST_ACTIVATE: begin
        out_d          = activated;
        output_valid_d = 1'b1;
        state_d        = ST_DONE;
      end
      ST_DONE: begin
        if (output_ready) begin
          output_valid_d = 1'b0;
          state_d        = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      beat_q         <= '0;
      acc_q          <= '0;
      inputs_q       <= '0;
      weight_q       <= '0;
      weight_snap_q  <= '0;
      bias_q         <= '0;
      bias_snap_q    <= '0;
      out_q          <= '0;
      output_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      beat_q         <= beat_d;
      acc_q          <= acc_d;
      inputs_q       <= inputs_d;
      weight_q       <= weight_d;
      weight_snap_q  <= weight_snap_d;
      bias_q         <= bias_d;
      bias_snap_q    <= bias_snap_d;
      out_q          <= out_d;
      output_valid_q <= output_valid_d;
    end
  end

  assign input_ready  = (state_q == ST_IDLE);
  assign out          = out_q;
  assign output_valid = output_valid_q;

endmodule

// File: tb/tb_fixed_point_neuron.sv
// Directed and randomized bench for fixed_point_neuron, running all three
// activation modes side by side against an integer-arithmetic reference.
module tb_fixed_point_neuron;

  localparam int DW = 16;
  localparam int NI = 4;
  localparam int NL = 2;

  logic              clock = 1'b0;
  logic              reset;
  logic              input_valid;
  logic [NI*DW-1:0]  input_bus;
  logic              weight_write;
  logic [1:0]        weight_address;
  logic [DW-1:0]     weight_data;
  logic              bias_write;
  logic [DW-1:0]     bias_data;
  logic              output_ready;

  logic              ready_r, ready_n, ready_l;
  logic              valid_r, valid_n, valid_l;
  logic [DW-1:0]     out_r, out_n, out_l;
  logic [2:0]        ready_vec, valid_vec;

  int assert_count = 0;
  int fail_count   = 0;
  int model_w [NI];
  int model_b;

  assign ready_vec = {ready_r, ready_n, ready_l};
  assign valid_vec = {valid_r, valid_n, valid_l};

  always #5 clock = ~clock;

  fixed_point_neuron #(.DATA_WIDTH(DW), .FRAC_BITS(8), .NUM_INPUTS(NI), .NUM_LANES(NL),
                       .ACTIVATION("relu")) u_relu (
    .clock(clock), .reset(reset), .input_valid(input_valid), .input_ready(ready_r),
    .inputs(input_bus), .weight_write(weight_write), .weight_address(weight_address),
    .weight_data(weight_data), .bias_write(bias_write), .bias_data(bias_data),
    .out(out_r), .output_valid(valid_r), .output_ready(output_ready));

  fixed_point_neuron #(.DATA_WIDTH(DW), .FRAC_BITS(8), .NUM_INPUTS(NI), .NUM_LANES(NL),
                       .ACTIVATION("none")) u_none (
    .clock(clock), .reset(reset), .input_valid(input_valid), .input_ready(ready_n),
    .inputs(input_bus), .weight_write(weight_write), .weight_address(weight_address),
    .weight_data(weight_data), .bias_write(bias_write), .bias_data(bias_data),
    .out(out_n), .output_valid(valid_n), .output_ready(output_ready));

  fixed_point_neuron #(.DATA_WIDTH(DW), .FRAC_BITS(8), .NUM_INPUTS(NI), .NUM_LANES(NL),
                       .ACTIVATION("leaky")) u_leaky (
    .clock(clock), .reset(reset), .input_valid(input_valid), .input_ready(ready_l),
    .inputs(input_bus), .weight_write(weight_write), .weight_address(weight_address),
    .weight_data(weight_data), .bias_write(bias_write), .bias_data(bias_data),
    .out(out_l), .output_valid(valid_l), .output_ready(output_ready));

  function automatic int s16(input int v);
    logic [15:0] t;
    t = v[15:0];
    return int'($signed(t));
  endfunction

  // Reference: exact integer dot product, floor division by 256, clamp, then activation.
  function automatic longint ref_model(input int x[NI], input int w[NI], input int b, input int mode);
    longint s;
    longint q;
    longint r;
    s = 0;
    for (int i = 0; i < NI; i++) s += longint'(x[i]) * longint'(w[i]);
    s += longint'(b) * 256;
    q = s / 256;
    if ((s % 256 != 0) && (s < 0)) q = q - 1;
    if (q > 32767) q = 32767;
    if (q < -32768) q = -32768;
    if (q < 0) begin
      if (mode == 0) begin
        q = 0;
      end else if (mode == 2) begin
        r = q / 8;
        if (q % 8 != 0) r = r - 1;
        q = r;
      end
    end
    return q;
  endfunction

  function automatic logic [NI*DW-1:0] pack_vec(input int x[NI]);
    logic [NI*DW-1:0] v;
    for (int i = 0; i < NI; i++) v[i*DW +: DW] = x[i][15:0];
    return v;
  endfunction

  function automatic logic [NI*DW-1:0] rand_vec();
    logic [NI*DW-1:0] v;
    for (int i = 0; i < NI; i++) v[i*DW +: DW] = 16'($urandom);
    return v;
  endfunction

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic checkOutput(input string tag, input logic signed [63:0] obs,
                             input logic signed [63:0] exp);
    assert_count++;
    assert (obs === exp) else begin
      fail_count++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic writeParams(input int idx, input int w, input bit do_bias, input int b);
    weight_write   = 1'b1;
    weight_address = idx[1:0];
    weight_data    = w[15:0];
    bias_write     = do_bias;
    bias_data      = b[15:0];
    tick();
    weight_write   = 1'b0;
    bias_write     = 1'b0;
    model_w[idx]   = s16(w);
    if (do_bias) model_b = s16(b);
  endtask

  // One full transaction from IDLE; optional disturbance while accumulating and a held-off consumer.
  task automatic applyStimulus(input int x[NI], input int hold_cycles, input bit disturb,
                               input bit write_on_accept);
    longint exp_r, exp_n, exp_l;
    exp_r = ref_model(x, model_w, model_b, 0);
    exp_n = ref_model(x, model_w, model_b, 1);
    exp_l = ref_model(x, model_w, model_b, 2);
    checkOutput("ready_before_accept", ready_vec, 3'b111);
    input_bus   = pack_vec(x);
    input_valid = 1'b1;
    if (write_on_accept) begin
      weight_write   = 1'b1;
      weight_address = 2'd1;
      weight_data    = 16'd768;
    end
    tick();
    input_valid  = 1'b0;
    weight_write = 1'b0;
    if (write_on_accept) model_w[1] = 768;
    checkOutput("ready_low_busy", ready_vec, 3'b000);
    checkOutput("valid_edge1", valid_vec, 3'b000);
    if (disturb) begin
      weight_write   = 1'b1;
      weight_address = 2'd0;
      weight_data    = 16'd512;
      bias_write     = 1'b1;
      bias_data      = 16'd1000;
      input_valid    = 1'b1;
      input_bus      = rand_vec();
    end
    tick();
    weight_write = 1'b0;
    bias_write   = 1'b0;
    input_valid  = 1'b0;
    checkOutput("valid_edge2", valid_vec, 3'b000);
    tick();
    checkOutput("valid_edge3", valid_vec, 3'b000);
    tick();
    checkOutput("valid_edge4", valid_vec, 3'b111);
    checkOutput("out_relu", $signed(out_r), exp_r);
    checkOutput("out_none", $signed(out_n), exp_n);
    checkOutput("out_leaky", $signed(out_l), exp_l);
    for (int h = 0; h < hold_cycles; h++) begin
      input_valid = 1'b1;
      input_bus   = rand_vec();
      tick();
      input_valid = 1'b0;
      checkOutput("hold_valid", valid_vec, 3'b111);
      checkOutput("hold_ready", ready_vec, 3'b000);
      checkOutput("hold_out_none", $signed(out_n), exp_n);
    end
    output_ready = 1'b1;
    tick();
    output_ready = 1'b0;
    checkOutput("valid_after_handshake", valid_vec, 3'b000);
    checkOutput("ready_after_handshake", ready_vec, 3'b111);
    checkOutput("out_kept_relu", $signed(out_r), exp_r);
    checkOutput("out_kept_leaky", $signed(out_l), exp_l);
  endtask

  initial begin
    int x [NI];
    reset          = 1'b1;
    input_valid    = 1'b0;
    input_bus      = '0;
    weight_write   = 1'b0;
    weight_address = '0;
    weight_data    = '0;
    bias_write     = 1'b0;
    bias_data      = '0;
    output_ready   = 1'b0;
    for (int i = 0; i < NI; i++) model_w[i] = 0;
    model_b = 0;

    tick();
    checkOutput("reset_ready", ready_vec, 3'b111);
    checkOutput("reset_valid", valid_vec, 3'b000);
    checkOutput("reset_out", $signed(out_n), 0);
    tick();
    reset = 1'b0;
    tick();

    $display("[TB] basic weighted sum");
    for (int i = 0; i < NI; i++) writeParams(i, 256, (i == 0), 0);
    x = '{256, 512, -256, 0};
    applyStimulus(x, 0, 1'b0, 1'b0);

    $display("[TB] negative sum through each activation");
    x = '{-256, -256, -256, -256};
    applyStimulus(x, 0, 1'b0, 1'b0);

    $display("[TB] saturation");
    for (int i = 0; i < NI; i++) writeParams(i, 32767, 1'b0, 0);
    x = '{32767, 32767, 32767, 32767};
    applyStimulus(x, 0, 1'b0, 1'b0);
    x = '{-32768, -32768, -32768, -32768};
    applyStimulus(x, 0, 1'b0, 1'b0);

    $display("[TB] consumer stall with ignored input pulses");
    for (int i = 0; i < NI; i++) writeParams(i, 256, 1'b0, 0);
    x = '{300, -700, 128, 45};
    applyStimulus(x, 10, 1'b0, 1'b0);

    $display("[TB] write and accept in the same cycle");
    x = '{256, 256, 256, 256};
    applyStimulus(x, 0, 1'b0, 1'b1);
    applyStimulus(x, 0, 1'b0, 1'b0);

    $display("[TB] randomized vectors");
    for (int t = 0; t < 12; t++) begin
      for (int i = 0; i < NI; i++) begin
        if (t % 2 == 0) writeParams(i, int'($urandom_range(0, 1023)) - 512, (i == NI-1),
                                    int'($urandom_range(0, 255)) - 128);
        else            writeParams(i, s16($urandom), (i == NI-1), s16($urandom));
      end
      for (int i = 0; i < NI; i++) begin
        if (t % 2 == 0) x[i] = int'($urandom_range(0, 2047)) - 1024;
        else            x[i] = s16($urandom);
      end
      applyStimulus(x, int'($urandom_range(0, 3)), 1'b0, 1'b0);
    end

    $display("[TB] writes and input changes during accumulate are dropped");
    for (int i = 0; i < NI; i++) writeParams(i, 256, (i == 0), 0);
    x = '{256, 512, -256, 0};
    applyStimulus(x, 0, 1'b1, 1'b0);
    applyStimulus(x, 0, 1'b0, 1'b0);

    $display("[TB] reset mid accumulate");
    input_bus   = pack_vec(x);
    input_valid = 1'b1;
    tick();
    input_valid = 1'b0;
    tick();
    #2 reset = 1'b1;
    #1;
    checkOutput("midreset_valid", valid_vec, 3'b000);
    checkOutput("midreset_out", $signed(out_r), 0);
    checkOutput("midreset_ready", ready_vec, 3'b111);
    tick();
    reset = 1'b0;
    for (int i = 0; i < NI; i++) model_w[i] = 0;
    model_b = 0;
    tick();
    x = '{1000, -2000, 3000, 4000};
    applyStimulus(x, 0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
